// File: rtl/lc3b_types.sv
// Shared LC-3b type package: word/line types plus the L2 burst geometry
// used by the line-to-word responder.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_burst;
    typedef logic [2:0]   lc3b_beat;

    localparam int L2_BEATS       = 8;
    localparam int L2_OFFSET_BITS = 4;

    // Byte address of word 'beat' inside the line whose base is 'line_base'.
    function automatic lc3b_word l2_word_address(
        input logic [15-L2_OFFSET_BITS:0] line_base,
        input lc3b_beat                   beat
    );
        return {line_base, beat, 1'b0};
    endfunction

    // Word 'beat' of a 128-bit line (word 0 in the low bits).
    function automatic lc3b_word l2_burst_word(
        input lc3b_burst line,
        input lc3b_beat  beat
    );
        return line[{beat, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/l2_burst_responder_buffer.sv
// l2_burst_buffer: 8 x 16-bit line assembly register. One word is written
// per accepted read beat; the whole line is always visible on 'line'.
// Cleared synchronously by rst.
module l2_burst_buffer
    import lc3b_types::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  lc3b_beat  idx,
    input  lc3b_word  wdata,
    output lc3b_burst line
);

    lc3b_word words_reg [L2_BEATS];

    // Indexed word write with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L2_BEATS; i++) begin
                words_reg[i] <= '0;
            end
        end else if (we) begin
            words_reg[idx] <= wdata;
        end
    end

    // Pack the word slots into the 128-bit line, slot 0 lowest.
    for (genvar gi = 0; gi < L2_BEATS; gi++) begin : g_pack
        assign line[gi*16 +: 16] = words_reg[gi];
    end

endmodule

// File: rtl/l2_burst_responder.sv
// l2_burst_responder: serves 128-bit line reads/writes from the L2 side as
// eight 16-bit word accesses on a narrow memory port, with one idle GAP
// cycle between beats. Build option L2R_CRITICAL_WORD_FIRST_EN starts reads
// at the requested word (address[3:1]) and wraps; writes always ascend.
module l2_burst_responder
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       read,
    input  logic       write,
    input  lc3b_word   address,
    input  lc3b_burst  wdata,
    output logic       resp,
    output lc3b_burst  rdata,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_byte_enable,
    output lc3b_word   mem_address,
    output lc3b_word   mem_wdata,
    input  logic       mem_resp,
    input  lc3b_word   mem_rdata
);

    localparam int BASE_W = 16 - L2_OFFSET_BITS;

    typedef enum logic [2:0] {
        IDLE,
        RBEAT,
        WBEAT,
        GAP,
        DONE
    } state_t;

    state_t              state_reg;
    logic                resp_reg;
    logic                mem_read_reg;
    logic                mem_write_reg;
    lc3b_word            mem_address_reg;
    lc3b_word            mem_wdata_reg;
    logic [BASE_W-1:0]   line_base_reg;
    lc3b_burst           wdata_reg;
    lc3b_beat            beat_reg;
    lc3b_beat            done_reg;
    logic                is_read_reg;

    lc3b_beat            beat_next;
    lc3b_beat            read_start_beat;
    logic                last_beat;
    logic                buf_we;
    logic                unused_addr_bits;

    // Word slot index wraps 7 -> 0; completion is judged by done_reg instead,
    // so a wrapped critical-word-first read still runs all eight beats.
    assign beat_next = beat_reg + 3'd1;
    assign last_beat = (done_reg == lc3b_beat'(L2_BEATS - 1));

`ifdef L2R_CRITICAL_WORD_FIRST_EN
    assign read_start_beat = address[3:1];
`else
    assign read_start_beat = '0;
`endif
    // Offset bits only matter in the critical-word-first build.
    assign unused_addr_bits = ^address[L2_OFFSET_BITS-1:0];

    // Transaction FSM; all port-facing outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            resp_reg        <= 1'b0;
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
            mem_address_reg <= '0;
            mem_wdata_reg   <= '0;
            line_base_reg   <= '0;
            wdata_reg       <= '0;
            beat_reg        <= '0;
            done_reg        <= '0;
            is_read_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Read has priority; a simultaneous write is dropped.
                    if (read) begin
                        line_base_reg   <= address[15:L2_OFFSET_BITS];
                        beat_reg        <= read_start_beat;
                        done_reg        <= '0;
                        is_read_reg     <= 1'b1;
                        mem_read_reg    <= 1'b1;
                        mem_address_reg <= l2_word_address(address[15:L2_OFFSET_BITS], read_start_beat);
                        state_reg       <= RBEAT;
                    end else if (write) begin
                        line_base_reg   <= address[15:L2_OFFSET_BITS];
                        wdata_reg       <= wdata;
                        beat_reg        <= '0;
                        done_reg        <= '0;
                        is_read_reg     <= 1'b0;
                        mem_write_reg   <= 1'b1;
                        mem_address_reg <= l2_word_address(address[15:L2_OFFSET_BITS], 3'd0);
                        mem_wdata_reg   <= l2_burst_word(wdata, 3'd0);
                        state_reg       <= WBEAT;
                    end
                end
                RBEAT, WBEAT: begin
                    if (mem_resp) begin
                        mem_read_reg  <= 1'b0;
                        mem_write_reg <= 1'b0;
                        done_reg      <= done_reg + 3'd1;
                        if (last_beat) begin
                            resp_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= GAP;
                        end
                    end
                end
                GAP: begin
                    // Set up the next beat so address/data are stable for the
                    // whole strobe window.
                    beat_reg        <= beat_next;
                    mem_address_reg <= l2_word_address(line_base_reg, beat_next);
                    if (!is_read_reg) begin
                        mem_wdata_reg <= l2_burst_word(wdata_reg, beat_next);
                    end
                    mem_read_reg    <= is_read_reg;
                    mem_write_reg   <= !is_read_reg;
                    state_reg       <= is_read_reg ? RBEAT : WBEAT;
                end
                DONE: begin
                    resp_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign buf_we = (state_reg == RBEAT) && mem_resp;

    l2_burst_buffer u_buffer (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_we),
        .idx   (beat_reg),
        .wdata (mem_rdata),
        .line  (rdata)
    );

    assign resp            = resp_reg;
    assign mem_read        = mem_read_reg;
    assign mem_write       = mem_write_reg;
    assign mem_byte_enable = 2'b11;
    assign mem_address     = mem_address_reg;
    assign mem_wdata       = mem_wdata_reg;

endmodule

// File: tb/tb_l2_burst_responder.sv
// Self-checking bench for l2_burst_responder: a word memory model with a
// programmable per-beat latency, expected accesses/lines queued at stimulus
// time and compared as the DUT completes them.
module tb_l2_burst_responder;
    import lc3b_types::*;

    logic       clk = 1'b0;
    logic       rst, read, write, resp, mem_read, mem_write, mem_resp;
    lc3b_word   address, mem_address, mem_wdata, mem_rdata;
    lc3b_burst  wdata, rdata;
    logic [1:0] mem_byte_enable;

    l2_burst_responder dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
        .wdata(wdata), .resp(resp), .rdata(rdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic     we;
        lc3b_word addr;
        lc3b_word data;
        int       start;
        logic     stable;
    } acc_t;

    acc_t      obs_q[$];
    acc_t      exp_q[$];
    int        resp_cyc_q[$];
    lc3b_burst resp_data_q[$];
    lc3b_burst exp_line_q[$];
    lc3b_word  mem_arr[lc3b_word];

    int checks = 0, errors = 0;
    int lat = 1, resp_cnt = 0, wr_cycles = 0;
    int win_cnt = 0, win_start = 0;
    lc3b_word win_addr, win_data;
    logic win_stable;

    function automatic lc3b_word rd_word(input lc3b_word a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return ~a;
    endfunction

    function automatic int first_beat(input lc3b_word a);
`ifdef L2R_CRITICAL_WORD_FIRST_EN
        return int'(a[3:1]);
`else
        return (a == 16'hFFFF) ? 1 : 0;
`endif
    endfunction

    // One clock step: memory model response and event logging at negedge.
    task automatic tick();
        @(negedge clk);
        if (mem_read || mem_write) begin
            if (win_cnt == 0) begin
                win_start = cyc; win_addr = mem_address; win_data = mem_wdata; win_stable = 1'b1;
            end else if (mem_address !== win_addr || mem_wdata !== win_data) begin
                win_stable = 1'b0;
            end
            win_cnt++;
            if (mem_write) wr_cycles++;
            if (win_cnt == lat) begin
                mem_resp = 1'b1;
                if (mem_read) mem_rdata = rd_word(mem_address);
                if (mem_write) mem_arr[mem_address] = mem_wdata;
                obs_q.push_back('{we: mem_write, addr: win_addr, data: win_data, start: win_start, stable: win_stable});
                win_cnt = 0;
            end else begin
                mem_resp = 1'b0;
            end
        end else begin
            mem_resp = 1'b0;
            win_cnt = 0;
        end
        if (resp) begin
            resp_cnt++;
            resp_cyc_q.push_back(cyc);
            resp_data_q.push_back(rdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; read = 1'b0; write = 1'b0;
        repeat (3) tick();
        checks++; if (resp !== 1'b0) begin errors++; $display("FAIL reset_resp got=%b exp=0", resp); end
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b exp=00", mem_read, mem_write); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (mem_address !== 16'h0 || mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_bus got=%h/%h exp=0000/0000", mem_address, mem_wdata); end
        checks++; if (mem_byte_enable !== 2'b11) begin errors++; $display("FAIL reset_byte_enable got=%b exp=11", mem_byte_enable); end
        rst = 1'b0;
        tick();
    endtask

    // Read 0x1234 at L=1; also covers the one-cycle resp pulse.
    task automatic test_read();
        int c0, n0, exp_start;
        lc3b_burst line;
        acc_t e, o;
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            mem_arr[16'h1230 + 16'(2*i)] = 16'hA000 + 16'(i);
            line[16*i +: 16] = 16'hA000 + 16'(i);
        end
        for (int k = 0; k < 8; k++) begin
            lc3b_beat b = lc3b_beat'(first_beat(16'h1234) + k);
            exp_q.push_back('{we: 1'b0, addr: 16'h1230 + {12'h0, b, 1'b0}, data: 16'h0, start: 0, stable: 1'b1});
        end
        exp_line_q.push_back(line);
        tick();
        n0 = resp_cnt; c0 = cyc; address = 16'h1234; read = 1'b1;
        for (int i = 0; i < 300 && resp_cnt == n0; i++) tick();
        read = 1'b0;
        checks++; if (resp_cnt == n0) begin errors++; $display("FAIL read_timeout got=no_resp exp=resp"); end
        if (resp_cyc_q.size() > 0) begin
            int rc = resp_cyc_q.pop_front();
            checks++; if (rc - c0 !== 16) begin errors++; $display("FAIL read_resp_cycle got=%0d exp=16", rc - c0); end
            $display("txn read addr=1234 resp_cycle=%0d", rc - c0);
        end
        if (resp_data_q.size() > 0) begin
            lc3b_burst got = resp_data_q.pop_front(), want = exp_line_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL read_rdata got=%h exp=%h", got, want); end
        end
        tick();
        checks++; if (resp !== 1'b0) begin errors++; $display("FAIL read_resp_pulse got=%b exp=0", resp); end
        exp_start = c0 + 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL read_access_missing got=none exp=%h", e.addr); end
            else begin
                o = obs_q.pop_front();
                if (o.we !== e.we || o.addr !== e.addr || !o.stable) begin errors++; $display("FAIL read_access got=we%b@%h stable=%b exp=we%b@%h", o.we, o.addr, o.stable, e.we, e.addr); end
                checks++; if (o.start !== exp_start) begin errors++; $display("FAIL read_strobe_cycle got=%0d exp=%0d", o.start - c0, exp_start - c0); end
                exp_start = o.start + lat + 1;
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL read_extra_access got=%0d exp=0", obs_q.size()); end
        obs_q.delete(); exp_line_q.delete();
    endtask

    // Write 0x0040 at L=3: data/address order, gap timing, rdata untouched.
    task automatic test_write();
        int c0, n0, w0, exp_start;
        lc3b_burst prev;
        acc_t e, o;
        lat = 3;
        prev = rdata;
        for (int i = 0; i < 8; i++) begin
            wdata[16*i +: 16] = 16'h5500 + 16'(i);
            exp_q.push_back('{we: 1'b1, addr: 16'h0040 + 16'(2*i), data: 16'h5500 + 16'(i), start: 0, stable: 1'b1});
        end
        exp_line_q.push_back(prev);
        tick();
        n0 = resp_cnt; w0 = wr_cycles; c0 = cyc; address = 16'h0040; write = 1'b1;
        for (int i = 0; i < 300 && resp_cnt == n0; i++) tick();
        write = 1'b0;
        checks++; if (resp_cnt == n0) begin errors++; $display("FAIL write_timeout got=no_resp exp=resp"); end
        if (resp_cyc_q.size() > 0) begin
            int rc = resp_cyc_q.pop_front();
            checks++; if (rc - c0 !== 32) begin errors++; $display("FAIL write_resp_cycle got=%0d exp=32", rc - c0); end
            $display("txn write addr=0040 resp_cycle=%0d", rc - c0);
        end
        if (resp_data_q.size() > 0) begin
            lc3b_burst got = resp_data_q.pop_front(), want = exp_line_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL write_rdata_changed got=%h exp=%h", got, want); end
        end
        checks++; if (wr_cycles - w0 !== 24) begin errors++; $display("FAIL write_strobe_cycles got=%0d exp=24", wr_cycles - w0); end
        exp_start = c0 + 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL write_access_missing got=none exp=%h", e.addr); end
            else begin
                o = obs_q.pop_front();
                if (o.we !== 1'b1 || o.addr !== e.addr || o.data !== e.data || !o.stable) begin errors++; $display("FAIL write_access got=we%b %h@%h stable=%b exp=we1 %h@%h", o.we, o.data, o.addr, o.stable, e.data, e.addr); end
                checks++; if (o.start !== exp_start) begin errors++; $display("FAIL write_strobe_cycle got=%0d exp=%0d", o.start - c0, exp_start - c0); end
                exp_start = o.start + lat + 1;
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL write_extra_access got=%0d exp=0", obs_q.size()); end
        obs_q.delete(); exp_line_q.delete();
        tick();
    endtask

    // Read 0x00CA at L=2; beat order depends on the critical-word-first build.
    task automatic test_critical_word();
        int c0, n0, exp_start;
        lc3b_burst line;
        acc_t e, o;
        lat = 2;
        for (int i = 0; i < 8; i++) begin
            mem_arr[16'h00C0 + 16'(2*i)] = 16'hB000 + 16'(i);
            line[16*i +: 16] = 16'hB000 + 16'(i);
        end
        for (int k = 0; k < 8; k++) begin
            lc3b_beat b = lc3b_beat'(first_beat(16'h00CA) + k);
            exp_q.push_back('{we: 1'b0, addr: 16'h00C0 + {12'h0, b, 1'b0}, data: 16'h0, start: 0, stable: 1'b1});
        end
        exp_line_q.push_back(line);
        tick();
        n0 = resp_cnt; c0 = cyc; address = 16'h00CA; read = 1'b1;
        for (int i = 0; i < 300 && resp_cnt == n0; i++) tick();
        read = 1'b0;
        checks++; if (resp_cnt == n0) begin errors++; $display("FAIL cwf_timeout got=no_resp exp=resp"); end
        if (resp_cyc_q.size() > 0) begin
            int rc = resp_cyc_q.pop_front();
            checks++; if (rc - c0 !== 24) begin errors++; $display("FAIL cwf_resp_cycle got=%0d exp=24", rc - c0); end
            $display("txn read addr=00ca resp_cycle=%0d", rc - c0);
        end
        if (resp_data_q.size() > 0) begin
            lc3b_burst got = resp_data_q.pop_front(), want = exp_line_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL cwf_rdata got=%h exp=%h", got, want); end
        end
        exp_start = c0 + 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL cwf_access_missing got=none exp=%h", e.addr); end
            else begin
                o = obs_q.pop_front();
                if (o.we !== 1'b0 || o.addr !== e.addr || !o.stable) begin errors++; $display("FAIL cwf_access got=we%b@%h exp=we0@%h", o.we, o.addr, e.addr); end
                checks++; if (o.start !== exp_start) begin errors++; $display("FAIL cwf_strobe_cycle got=%0d exp=%0d", o.start - c0, exp_start - c0); end
                exp_start = o.start + lat + 1;
            end
        end
        obs_q.delete(); exp_line_q.delete();
        tick();
    endtask

    // read and write together: only the read happens, one resp.
    task automatic test_read_write_both();
        int n0, w0;
        lc3b_burst line;
        acc_t e, o;
        lat = 1;
        for (int i = 0; i < 8; i++) begin
            line[16*i +: 16] = rd_word(16'h0100 + 16'(2*i));
            wdata[16*i +: 16] = 16'hC300 + 16'(i);
            exp_q.push_back('{we: 1'b0, addr: 16'h0100 + 16'(2*i), data: 16'h0, start: 0, stable: 1'b1});
        end
        exp_line_q.push_back(line);
        tick();
        n0 = resp_cnt; w0 = wr_cycles; address = 16'h0100; read = 1'b1; write = 1'b1;
        for (int i = 0; i < 300 && resp_cnt == n0; i++) tick();
        read = 1'b0; write = 1'b0;
        repeat (20) tick();
        checks++; if (resp_cnt - n0 !== 1) begin errors++; $display("FAIL both_resp_count got=%0d exp=1", resp_cnt - n0); end
        checks++; if (wr_cycles - w0 !== 0) begin errors++; $display("FAIL both_mem_write got=%0d exp=0", wr_cycles - w0); end
        if (resp_data_q.size() > 0) begin
            lc3b_burst got = resp_data_q.pop_front(), want = exp_line_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL both_rdata got=%h exp=%h", got, want); end
            $display("txn read+write addr=0100 rdata=%h", got);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL both_access_missing got=none exp=%h", e.addr); end
            else begin
                o = obs_q.pop_front();
                if (o.we !== 1'b0 || o.addr !== e.addr) begin errors++; $display("FAIL both_access got=we%b@%h exp=we0@%h", o.we, o.addr, e.addr); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL both_extra_access got=%0d exp=0", obs_q.size()); end
        obs_q.delete(); resp_cyc_q.delete(); resp_data_q.delete(); exp_line_q.delete();
    endtask

    // Request held across resp: second transaction follows with one IDLE cycle.
    task automatic test_back_to_back();
        int c0, n0, r1, exp_start, k;
        lc3b_burst line;
        acc_t e, o;
        lat = 1;
        for (int i = 0; i < 8; i++) line[16*i +: 16] = 16'hA000 + 16'(i);
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 8; i++) exp_q.push_back('{we: 1'b0, addr: 16'h1230 + 16'(2*i), data: 16'h0, start: 0, stable: 1'b1});
            exp_line_q.push_back(line);
        end
        tick();
        n0 = resp_cnt; c0 = cyc; address = 16'h1230; read = 1'b1;
        for (int i = 0; i < 400 && resp_cnt < n0 + 2; i++) tick();
        read = 1'b0;
        checks++; if (resp_cnt - n0 !== 2) begin errors++; $display("FAIL b2b_resp_count got=%0d exp=2", resp_cnt - n0); end
        r1 = (resp_cyc_q.size() > 0) ? resp_cyc_q[0] : -100;
        while (resp_data_q.size() > 0 && exp_line_q.size() > 0) begin
            lc3b_burst got = resp_data_q.pop_front(), want = exp_line_q.pop_front();
            checks++; if (got !== want) begin errors++; $display("FAIL b2b_rdata got=%h exp=%h", got, want); end
            $display("txn read addr=1230 back_to_back rdata=%h", got);
        end
        exp_start = c0 + 1; k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_access_missing got=none exp=%h", e.addr); end
            else begin
                o = obs_q.pop_front();
                if (o.we !== 1'b0 || o.addr !== e.addr) begin errors++; $display("FAIL b2b_access got=we%b@%h exp=we0@%h", o.we, o.addr, e.addr); end
                if (k == 8) exp_start = r1 + 2;
                checks++; if (o.start !== exp_start) begin errors++; $display("FAIL b2b_strobe_cycle beat=%0d got=%0d exp=%0d", k, o.start - c0, exp_start - c0); end
                exp_start = o.start + lat + 1;
            end
            k++;
        end
        obs_q.delete(); resp_cyc_q.delete(); resp_data_q.delete(); exp_line_q.delete();
        tick();
    endtask

    // rst during the fourth beat of a read: abandon, clear, no resp.
    task automatic test_reset_mid();
        int n0;
        lat = 1;
        tick();
        n0 = resp_cnt; address = 16'h1234; read = 1'b1;
        for (int i = 0; i < 100 && obs_q.size() < 4; i++) tick();
        checks++; if (obs_q.size() < 4) begin errors++; $display("FAIL rstmid_timeout got=%0d exp=4", obs_q.size()); end
        rst = 1'b1; read = 1'b0;
        tick();
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL rstmid_strobes got=%b%b exp=00", mem_read, mem_write); end
        checks++; if (rdata !== '0) begin errors++; $display("FAIL rstmid_rdata got=%h exp=0", rdata); end
        checks++; if (resp !== 1'b0) begin errors++; $display("FAIL rstmid_resp got=%b exp=0", resp); end
        rst = 1'b0;
        obs_q.delete();
        repeat (40) tick();
        checks++; if (resp_cnt !== n0) begin errors++; $display("FAIL rstmid_no_resp got=%0d exp=0", resp_cnt - n0); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_idle got=%0d exp=0", obs_q.size()); end
        $display("txn read addr=1234 aborted_by_reset");
        obs_q.delete(); resp_cyc_q.delete(); resp_data_q.delete();
    endtask

    initial begin
        rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        test_reset();
        test_read();
        test_write();
        test_critical_word();
        test_read_write_both();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_burst_responder.md
# l2_burst_responder

Responder end of the 128-bit L2 line interface driven by the DGM top level. The block accepts one line read or write per transaction and serialises it into eight 16-bit word accesses on a narrow word-wide memory port. It returns `resp` with the assembled line for reads, or after the eighth beat for writes. It sits between `DGM` and a 16-bit word memory, replacing a native 128-bit memory.

## Interface
- No parameters. Line = 8 beats × 16 bits; beat count is fixed.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `read` in 1: line read request; held until `resp`.
- `write` in 1: line write request; held until `resp`.
- `address` in 16: byte address; line base = `address[15:4]`.
- `wdata` in 128: write line; word i = `wdata[16i+15:16i]`.
- `resp` out 1: one-cycle completion pulse.
- `rdata` out 128: assembled read line; valid in the `resp` cycle.
- `mem_read` out 1: word read strobe; held until `mem_resp`.
- `mem_write` out 1: word write strobe; held until `mem_resp`.
- `mem_byte_enable` out 2: always 2'b11.
- `mem_address` out 16: word address `{line_base, beat[2:0], 1'b0}`.
- `mem_wdata` out 16: current write word.
- `mem_resp` in 1: word access complete.
- `mem_rdata` in 16: read word; sampled when `mem_resp` is high.

## Operation
- States are IDLE, RBEAT, WBEAT, GAP and DONE.
- IDLE: if `read`, capture `address[15:4]`, set the beat counter to its start value and go to RBEAT. Else if `write`, also capture `wdata` and go to WBEAT.
  - `read` and `write` both high: read wins; the write is not performed.
- RBEAT: `mem_read`=1. On `mem_resp`, write `mem_rdata` into buffer slot `beat`. Then go to DONE if this was the 8th beat, else go to GAP.
- WBEAT: `mem_write`=1 and `mem_wdata` = captured word `beat`. On `mem_resp`, go to DONE if this was the 8th beat, else go to GAP.
- GAP: both strobes are 0 for exactly one cycle. Increment the beat counter modulo 8, then return to RBEAT or WBEAT, whichever was active.
- DONE: `resp`=1 for one cycle, then go to IDLE.
- A request still asserted in the cycle after `resp` is treated as a new transaction.
- `address`, `wdata`, `read` and `write` are not re-sampled during a transaction.
- Beat counter is 3 bits and wraps 7→0. A separate 3-bit beats-done count decides completion, so wrap never terminates early.
- `rdata` is the buffer register. It holds its value between transactions; write transactions do not modify it.
- Reset values: state IDLE; `resp`, `mem_read`, `mem_write` = 0; `rdata` = 0; `mem_address` = 0; `mem_wdata` = 0; `mem_byte_enable` = 2'b11.
- Reset mid-transaction: return to IDLE next cycle with strobes deasserted. The in-flight downstream access is abandoned and no `resp` is issued.

## Timing
- Let L = cycles that `mem_read`/`mem_write` is high per beat, including the `mem_resp` cycle (L ≥ 1).
- Request seen in IDLE at cycle 0 → first strobe at cycle 1 → `resp` at cycle 8L+8.
- With L=1, `resp` is at cycle 16.
- `mem_address`/`mem_wdata` are registered and stable for the whole strobe window.
- `resp` and `rdata` are registered; there is no combinational path from `mem_resp` to `resp`.
- Back-to-back requests: minimum 1 IDLE cycle between `resp` and the next first strobe.

## Configuration
- `L2R_CRITICAL_WORD_FIRST_EN` defined: reads start at beat `address[3:1]` and wrap modulo 8. The word is still placed in buffer slot `beat`, so `rdata` layout is unchanged.
- Not defined: reads start at beat 0, ascending.
- Writes always run beats 0..7 ascending in both builds.

## Structure
- Shared package `lc3b_types`: reuse `lc3b_word` (16) and `lc3b_burst` (128).
- Add to the package:
  - `lc3b_beat` (3-bit) typedef;
  - `L2_BEATS` = 8;
  - `L2_OFFSET_BITS` = 4.
- The FSM state enum stays local to `l2_burst_responder`.
- One sub-module, `l2_burst_buffer`: an 8×16 register with indexed word write, full 128-bit read and synchronous clear on `rst`.

## Test plan
- Read, address 16'h1234, memory word at 16'h1230+2i = 16'hA000+i, L=1:
  - `mem_address` sequence 1230,1232,…,123E;
  - `resp` at cycle 16;
  - `rdata` = {A007,…,A000}.
- Write, address 16'h0040, `wdata` word i = 16'h5500+i, L=3:
  - eight `mem_write` windows of 3 cycles, each followed by one GAP cycle;
  - `mem_wdata` 5500…5507 at 0040…004E;
  - `resp` at cycle 32;
  - `rdata` unchanged.
- With `L2R_CRITICAL_WORD_FIRST_EN`, read address 16'h00CA:
  - beat order 5,6,7,0,1,2,3,4;
  - addresses 00CA,00CC,00CE,00C0…00C8;
  - `rdata` identical to the ascending-order read.
- `read` and `write` high together, address 16'h0100:
  - only `mem_read` strobes;
  - no `mem_write` at all;
  - one `resp`.
- `rst` asserted during beat 3 of a read:
  - next cycle: state IDLE, strobes 0, `rdata` 0;
  - no `resp` ever issued for that transaction.
- Request held high after `resp`:
  - a second transaction starts;
  - its first strobe appears exactly 2 cycles after the first `resp`.
